id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register of the deep MIPS pipeline; sits directly downstream of the main decode controller.
- Latches the controller's control bundle plus register operands, register specifiers and the extended immediate into the EX stage.
- Contains load-use hazard detection. On a hazard it inserts a bubble and stalls PC and IF/ID.
- Supports branch flush from a later stage and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, datapath width for PC+4, register data and immediate.
- REG_W, 5, register specifier width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_instr  in  32  ID instruction; fields used: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- id_pc_plus4  in  DATA_W  PC+4 of the ID instruction.
- id_rs_data  in  DATA_W  register file read port A.
- id_rt_data  in  DATA_W  register file read port B.
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  controller outputs.
- id_alu_op  in  2  controller ALUOp.
- flush  in  1  branch resolved taken; kill the ID instruction.
- ex_valid  out  1  EX holds a real instruction.
- ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  registered control.
- ex_alu_op  out  2  registered ALUOp.
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered datapath values.
- ex_rs, ex_rt, ex_rd  out  REG_W each  registered specifiers, used by forwarding and the RegDst mux.
- stall  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_cnt  out  CNT_W  bubbles inserted due to hazards, saturating.

Behaviour:
- Reset (rst_n=0, async): all ex_* outputs, ex_valid and bubble_cnt are 0. stall evaluates to 0 because ex_valid=0.
- The ID instruction uses rt as a source when its opcode is 000000 (R-type), 101011 (sw) or 000100 (beq). For lw and ori, rt is a destination only.
- Hazard condition (combinational): ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & !flush & (ex_rt == rs | (uses_rt & ex_rt == rt)).
- stall = hazard. Latency from hazard to stall is 0 cycles (same cycle).
- Immediate extension: opcode 001101 (ori) zero-extends imm to DATA_W; all other opcodes sign-extend.
- Each rising edge applies exactly one of the following, in priority order:
  1. flush=1: ex_valid=0, all control outputs 0, datapath fields don't-care (implemented as hold). bubble_cnt unchanged.
  2. hazard=1: bubble. ex_valid=0, all control outputs 0. bubble_cnt increments unless it is at all-ones, where it holds.
  3. else: capture all id_* values. ex_valid=id_valid. Control is gated: if id_valid=0, all control outputs are 0.
- Flush and hazard in the same cycle: flush wins, stall=0, and the counter does not increment.
- A bubble always has ex_mem_read=0, so a single lw can never cause more than one consecutive stall cycle.
- ex_rt=0 never triggers a hazard, since $zero is never a true dependency.
- Reset asserted mid-stall: outputs clear immediately and stall drops in the same cycle.

Test Plan:
- Reset: hold rst_n=0 with random id_* inputs -> all ex_* outputs = 0, stall=0, bubble_cnt=0. After release, a valid add $3,$1,$2 (0x00221820) appears on the outputs next cycle with ex_reg_dst=1, ex_alu_op=10, ex_rd=3.
- Load-use: lw $5,4($1) then add $6,$5,$7 -> stall=1 for exactly 1 cycle. Next edge: ex_valid=0, ex_reg_write=0, bubble_cnt=1. Following edge: the add is captured with ex_rs=5.
- rt-only use: lw $5 followed by ori $5,$5... -> stall (rs match). lw $5 followed by lw $5,0($2) -> no stall (rt is a destination, rs=2).
- $zero: lw $0,0($1) followed by add $2,$0,$0 -> stall=0, bubble_cnt unchanged.
- Flush vs hazard: load-use condition present with flush=1 -> stall=0, ex_valid=0, bubble_cnt unchanged.
- Immediate and saturation: ori with imm 0x8000 -> ex_imm=0x00008000; sw with imm 0x8000 -> ex_imm=0xFFFF8000. Preload or force bubble_cnt to 0xFFFF and cause a hazard -> bubble_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating bubble counter.
module id_ex_hazard_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [31:0]       id_instr,
   input  logic [DATA_W-1:0] id_pc_plus4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic              id_reg_dst,
   input  logic              id_alu_src,
   input  logic              id_mem_to_reg,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic [1:0]        id_alu_op,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_reg_dst,
   output logic              ex_alu_src,
   output logic              ex_mem_to_reg,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic [1:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_pc_plus4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic              stall,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   logic [5:0]        w_opcode;
   logic [REG_W-1:0]  w_rs;
   logic [REG_W-1:0]  w_rt;
   logic [REG_W-1:0]  w_rd;
   logic [15:0]       w_imm16;
   logic [DATA_W-1:0] w_imm_ext;
   logic              w_uses_rt;
   logic              w_hazard;
   logic [8:0]        w_id_ctrl;

   logic              r_valid;
   logic [8:0]        r_ctrl;
   logic [DATA_W-1:0] r_pc_plus4;
   logic [DATA_W-1:0] r_rs_data;
   logic [DATA_W-1:0] r_rt_data;
   logic [DATA_W-1:0] r_imm;
   logic [REG_W-1:0]  r_rs;
   logic [REG_W-1:0]  r_rt;
   logic [REG_W-1:0]  r_rd;
   logic [CNT_W-1:0]  r_bubble_cnt;

   assign w_opcode  = id_instr[31:26];
   assign w_rs      = REG_W'(id_instr[25:21]);
   assign w_rt      = REG_W'(id_instr[20:16]);
   assign w_rd      = REG_W'(id_instr[15:11]);
   assign w_imm16   = id_instr[15:0];
   assign w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) || (w_opcode == OP_BEQ);
   assign w_imm_ext = (w_opcode == OP_ORI) ? {{(DATA_W-16){1'b0}}, w_imm16}
                                           : {{(DATA_W-16){w_imm16[15]}}, w_imm16};
   assign w_id_ctrl = {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
                       id_mem_read, id_mem_write, id_branch, id_alu_op};

   // A bubble clears ex_mem_read, so one load can stall for at most one cycle.
   assign w_hazard = r_valid & r_ctrl[4] & (r_rt != '0) & id_valid & ~flush &
                     ((r_rt == w_rs) | (w_uses_rt & (r_rt == w_rt)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_ctrl       <= '0;
         r_pc_plus4   <= '0;
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_imm        <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_bubble_cnt <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (w_hazard) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end else begin
         r_valid    <= id_valid;
         r_ctrl     <= id_valid ? w_id_ctrl : 9'd0;
         r_pc_plus4 <= id_pc_plus4;
         r_rs_data  <= id_rs_data;
         r_rt_data  <= id_rt_data;
         r_imm      <= w_imm_ext;
         r_rs       <= w_rs;
         r_rt       <= w_rt;
         r_rd       <= w_rd;
      end
   end

   assign ex_valid      = r_valid;
   assign ex_reg_dst    = r_ctrl[8];
   assign ex_alu_src    = r_ctrl[7];
   assign ex_mem_to_reg = r_ctrl[6];
   assign ex_reg_write  = r_ctrl[5];
   assign ex_mem_read   = r_ctrl[4];
   assign ex_mem_write  = r_ctrl[3];
   assign ex_branch     = r_ctrl[2];
   assign ex_alu_op     = r_ctrl[1:0];
   assign ex_pc_plus4   = r_pc_plus4;
   assign ex_rs_data    = r_rs_data;
   assign ex_rt_data    = r_rt_data;
   assign ex_imm        = r_imm;
   assign ex_rs         = r_rs;
   assign ex_rt         = r_rt;
   assign ex_rd         = r_rd;
   assign stall         = w_hazard;
   assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed vector bench for id_ex_hazard_stage; a second instance with a 2-bit
// counter shares the stimulus so counter saturation is reached quickly.
module tb_id_ex_hazard_stage;

   localparam logic [8:0] CR   = 9'b1_0_0_1_0_0_0_10;
   localparam logic [8:0] CLW  = 9'b0_1_1_1_1_0_0_00;
   localparam logic [8:0] CSW  = 9'b0_1_0_0_0_1_0_00;
   localparam logic [8:0] CORI = 9'b0_1_0_1_0_0_0_11;
   localparam logic [8:0] CBEQ = 9'b0_0_0_0_0_0_1_01;

   localparam logic [31:0] ADD3  = 32'h00221820; // add $3,$1,$2
   localparam logic [31:0] LW5   = 32'h8C250004; // lw  $5,4($1)
   localparam logic [31:0] ADD6  = 32'h00A73020; // add $6,$5,$7
   localparam logic [31:0] LW5R2 = 32'h8C450000; // lw  $5,0($2)
   localparam logic [31:0] ORI5  = 32'h34A58000; // ori $5,$5,0x8000
   localparam logic [31:0] SW5   = 32'hAC650000; // sw  $5,0($3)
   localparam logic [31:0] LW0   = 32'h8C200000; // lw  $0,0($1)
   localparam logic [31:0] ADD2  = 32'h00001020; // add $2,$0,$0
   localparam logic [31:0] BEQ   = 32'h10850002; // beq $4,$5,2
   localparam logic [31:0] SWX   = 32'hAC258000; // sw  $5,-32768($1)

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_instr, id_pc_plus4, id_rs_data, id_rt_data;
   logic        id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
   logic        id_mem_read, id_mem_write, id_branch;
   logic [1:0]  id_alu_op;
   logic        flush;

   logic        ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
   logic        ex_mem_read, ex_mem_write, ex_branch;
   logic [1:0]  ex_alu_op;
   logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        stall;
   logic [15:0] bubble_cnt;

   logic        s_valid, s_reg_dst, s_alu_src, s_mem_to_reg, s_reg_write;
   logic        s_mem_read, s_mem_write, s_branch;
   logic [1:0]  s_alu_op;
   logic [31:0] s_pc_plus4, s_rs_data, s_rt_data, s_imm;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic        s_stall;
   logic [1:0]  s_bubble_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_hazard_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_alu_op(id_alu_op), .flush(flush),
      .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .stall(stall), .bubble_cnt(bubble_cnt)
   );

   id_ex_hazard_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_alu_op(id_alu_op), .flush(flush),
      .ex_valid(s_valid), .ex_reg_dst(s_reg_dst), .ex_alu_src(s_alu_src),
      .ex_mem_to_reg(s_mem_to_reg), .ex_reg_write(s_reg_write),
      .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write), .ex_branch(s_branch),
      .ex_alu_op(s_alu_op), .ex_pc_plus4(s_pc_plus4), .ex_rs_data(s_rs_data),
      .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt),
      .ex_rd(s_rd), .stall(s_stall), .bubble_cnt(s_bubble_cnt)
   );

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic [8:0]  ctrl;
      logic        flush;
      logic        exp_stall;
      logic        exp_valid;
      logic [8:0]  exp_ctrl;
      logic [4:0]  exp_rs, exp_rt, exp_rd;
      logic [31:0] exp_imm;
      logic        cap;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(logic v, logic [31:0] ins, logic [8:0] c, logic f,
                               logic es, logic ev, logic [8:0] ec, logic [4:0] rs,
                               logic [4:0] rt, logic [4:0] rd, logic [31:0] imm,
                               logic cap, int cnt);
      vec_t t;
      t.valid = v; t.instr = ins; t.ctrl = c; t.flush = f;
      t.exp_stall = es; t.exp_valid = ev; t.exp_ctrl = ec;
      t.exp_rs = rs; t.exp_rt = rt; t.exp_rd = rd; t.exp_imm = imm;
      t.cap = cap; t.exp_cnt = cnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [8:0] c,
                        input logic f, input logic [31:0] pc, input logic [31:0] ra,
                        input logic [31:0] rb);
      id_valid = v; id_instr = ins; flush = f;
      {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
       id_mem_read, id_mem_write, id_branch, id_alu_op} = c;
      id_pc_plus4 = pc; id_rs_data = ra; id_rt_data = rb;
   endtask

   function automatic logic [8:0] ex_ctrl();
      return {ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
              ex_mem_read, ex_mem_write, ex_branch, ex_alu_op};
   endfunction

   initial begin
      logic [31:0] m_pc, m_ra, m_rb;
      int          sat;

      tbl[0]  = mk(1, ADD3,  CR,   0, 0, 1, CR,   1, 2, 3,  32'h00001820, 1, 0);
      tbl[1]  = mk(1, LW5,   CLW,  0, 0, 1, CLW,  1, 5, 0,  32'h00000004, 1, 0);
      tbl[2]  = mk(1, ADD6,  CR,   0, 1, 0, 9'd0, 1, 5, 0,  32'h00000004, 0, 1);
      tbl[3]  = mk(1, ADD6,  CR,   0, 0, 1, CR,   5, 7, 6,  32'h00003020, 1, 1);
      tbl[4]  = mk(1, LW5R2, CLW,  0, 0, 1, CLW,  2, 5, 0,  32'h00000000, 1, 1);
      tbl[5]  = mk(1, LW5R2, CLW,  0, 0, 1, CLW,  2, 5, 0,  32'h00000000, 1, 1);
      tbl[6]  = mk(1, ORI5,  CORI, 0, 1, 0, 9'd0, 2, 5, 0,  32'h00000000, 0, 2);
      tbl[7]  = mk(1, ORI5,  CORI, 0, 0, 1, CORI, 5, 5, 16, 32'h00008000, 1, 2);
      tbl[8]  = mk(1, LW5,   CLW,  0, 0, 1, CLW,  1, 5, 0,  32'h00000004, 1, 2);
      tbl[9]  = mk(1, SW5,   CSW,  0, 1, 0, 9'd0, 1, 5, 0,  32'h00000004, 0, 3);
      tbl[10] = mk(1, SW5,   CSW,  0, 0, 1, CSW,  3, 5, 0,  32'h00000000, 1, 3);
      tbl[11] = mk(1, LW0,   CLW,  0, 0, 1, CLW,  1, 0, 0,  32'h00000000, 1, 3);
      tbl[12] = mk(1, ADD2,  CR,   0, 0, 1, CR,   0, 0, 2,  32'h00001020, 1, 3);
      tbl[13] = mk(1, LW5,   CLW,  0, 0, 1, CLW,  1, 5, 0,  32'h00000004, 1, 3);
      tbl[14] = mk(1, ADD6,  CR,   1, 0, 0, 9'd0, 1, 5, 0,  32'h00000004, 0, 3);
      tbl[15] = mk(0, ADD6,  CR,   0, 0, 0, 9'd0, 5, 7, 6,  32'h00003020, 1, 3);
      tbl[16] = mk(1, LW5,   CLW,  0, 0, 1, CLW,  1, 5, 0,  32'h00000004, 1, 3);
      tbl[17] = mk(0, ADD6,  CR,   0, 0, 0, 9'd0, 5, 7, 6,  32'h00003020, 1, 3);
      tbl[18] = mk(1, LW5,   CLW,  0, 0, 1, CLW,  1, 5, 0,  32'h00000004, 1, 3);
      tbl[19] = mk(1, BEQ,   CBEQ, 0, 1, 0, 9'd0, 1, 5, 0,  32'h00000004, 0, 4);
      tbl[20] = mk(1, SWX,   CSW,  0, 0, 1, CSW,  1, 5, 16, 32'hFFFF8000, 1, 4);

      // Reset with random inputs toggling across several edges.
      rst_n = 1'b0;
      drive(1'b1, LW5, CLW, 1'b0, 32'h0, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         drive(1'b1, $urandom, 9'($urandom), 1'b0, $urandom, $urandom, $urandom);
      end
      #2;
      chk("rst ex_valid", ex_valid, 0);
      chk("rst ctrl", ex_ctrl(), 0);
      chk("rst stall", stall, 0);
      chk("rst bubble_cnt", bubble_cnt, 0);
      chk("rst ex_imm", ex_imm, 0);
      chk("rst ex_pc_plus4", ex_pc_plus4, 0);
      chk("rst specifiers", {17'd0, ex_rs, ex_rt, ex_rd}, 0);
      chk("rst ex_rs_data", ex_rs_data, 0);
      chk("rst ex_rt_data", ex_rt_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      m_pc = 32'h0; m_ra = 32'h0; m_rb = 32'h0;
      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].valid, tbl[i].instr, tbl[i].ctrl, tbl[i].flush,
               32'h0040_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
         #3;
         chk($sformatf("v%0d stall", i), stall, tbl[i].exp_stall);
         @(posedge clk); #1;
         if (tbl[i].cap) begin
            m_pc = 32'h0040_0000 + 32'(4 * i);
            m_ra = 32'hA000_0000 + 32'(i);
            m_rb = 32'hB000_0000 + 32'(i);
         end
         sat = (tbl[i].exp_cnt > 3) ? 3 : tbl[i].exp_cnt;
         chk($sformatf("v%0d ex_valid", i), ex_valid, tbl[i].exp_valid);
         chk($sformatf("v%0d ctrl", i), ex_ctrl(), tbl[i].exp_ctrl);
         chk($sformatf("v%0d rs/rt/rd", i), {ex_rs, ex_rt, ex_rd},
             {tbl[i].exp_rs, tbl[i].exp_rt, tbl[i].exp_rd});
         chk($sformatf("v%0d ex_imm", i), ex_imm, tbl[i].exp_imm);
         chk($sformatf("v%0d bubble_cnt", i), bubble_cnt, tbl[i].exp_cnt);
         chk($sformatf("v%0d sat bubble_cnt", i), s_bubble_cnt, sat);
         chk($sformatf("v%0d ex_pc_plus4", i), ex_pc_plus4, m_pc);
         chk($sformatf("v%0d ex_rs_data", i), ex_rs_data, m_ra);
         chk($sformatf("v%0d ex_rt_data", i), ex_rt_data, m_rb);
      end

      // Reset asserted mid-stall: outputs and stall clear without a clock edge.
      drive(1'b1, LW5, CLW, 1'b0, 32'h100, 32'h1, 32'h2);
      @(posedge clk); #1;
      drive(1'b1, ADD6, CR, 1'b0, 32'h104, 32'h3, 32'h4);
      #2;
      chk("midrst stall before", stall, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst stall", stall, 0);
      chk("midrst ex_valid", ex_valid, 0);
      chk("midrst ex_mem_read", ex_mem_read, 0);
      chk("midrst bubble_cnt", bubble_cnt, 0);
      chk("midrst sat bubble_cnt", s_bubble_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
